rib_rr_arbiter: RTL and testbench

Registered round-robin arbiter that sequences ownership of the RIB interconnect among its 4 masters: m0 ex/mem, m1 instruction fetch, m2 and m3 debug/peripheral masters.
- Replaces fixed-priority combinational grant with a 1-cycle-latency registered grant.
- Supports locked multi-beat ownership with a bounded hold time.
- Drives the grant select into the RIB mux and the pipeline hold flag to the core.

---
 rtl/rib_rr_arbiter.sv | 120 ++++++++++++
 tb/tb_rib_rr_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/rib_rr_arbiter.sv
// Registered round-robin arbiter for the 4 RIB masters with bounded locked ownership.
// Optional macro RIB_ARB_PRIO3_EN: master 3 (debug) gets absolute priority and preempts locked owners.
module rib_rr_arbiter #(
  parameter int unsigned NUM_M    = 4,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HCW      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM_M-1:0] req_i,
  input  logic [NUM_M-1:0] lock_i,
  output logic [1:0]       grant_o,
  output logic             grant_vld_o,
  output logic [NUM_M-1:0] gnt_o,
  output logic             hold_flag_o,
  output logic             starve_o
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t         state_q;
  logic [1:0]     grant_q;
  logic           grant_vld_q;
  logic [1:0]     last_ptr_q;
  logic [HCW-1:0] hold_cnt_q;
  logic           starve_q;

  // First set bit of r scanning upward from p+1 (wrapping), so p itself is lowest priority.
  function automatic logic [1:0] rr_pick(input logic [NUM_M-1:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic       found;
    rr_pick = p;
    found   = 1'b0;
    for (int unsigned k = 1; k <= NUM_M; k++) begin
      idx = p + k[1:0];
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [1:0] pick(input logic [NUM_M-1:0] r, input logic [1:0] p);
`ifdef RIB_ARB_PRIO3_EN
    pick = r[3] ? 2'd3 : rr_pick(r, p);
`else
    pick = rr_pick(r, p);
`endif
  endfunction

  logic             own_locked;
  logic [NUM_M-1:0] others;
  logic             hold_max;

  assign own_locked = req_i[grant_q] & lock_i[grant_q];
  assign others     = req_i & ~(NUM_M'(1) << grant_q);
  assign hold_max   = (hold_cnt_q >= HCW'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= 2'h1;
      grant_vld_q <= 1'b0;
      last_ptr_q  <= 2'h3;
      hold_cnt_q  <= '0;
      starve_q    <= 1'b0;
    end else begin
      starve_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req_i) begin
            state_q     <= OWN;
            grant_q     <= pick(req_i, last_ptr_q);
            last_ptr_q  <= pick(req_i, last_ptr_q);
            grant_vld_q <= 1'b1;
            hold_cnt_q  <= '0;
          end
        end
        OWN: begin
`ifdef RIB_ARB_PRIO3_EN
          if (req_i[3] && grant_q != 2'd3) begin
            grant_q    <= 2'd3;
            last_ptr_q <= 2'd3;
            hold_cnt_q <= '0;
            starve_q   <= own_locked;
          end else
`endif
          if (own_locked && !hold_max) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end else if (own_locked) begin
            // Forced release: owner excluded; it keeps the bus only when nobody else asks.
            hold_cnt_q <= '0;
            if (|others) begin
              grant_q    <= pick(others, grant_q);
              last_ptr_q <= pick(others, grant_q);
              starve_q   <= 1'b1;
            end
          end else if (|req_i) begin
            grant_q    <= pick(req_i, grant_q);
            last_ptr_q <= pick(req_i, grant_q);
            hold_cnt_q <= '0;
          end else begin
            state_q     <= IDLE;
            grant_vld_q <= 1'b0;
            hold_cnt_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_o     = grant_q;
  assign grant_vld_o = grant_vld_q;
  assign starve_o    = starve_q;
  assign gnt_o       = grant_vld_q ? (NUM_M'(1) << grant_q) : '0;
  // Fetch alone never stalls the core.
  assign hold_flag_o = req_i[0] | req_i[2] | req_i[3] | (grant_vld_q & (grant_q != 2'h1));

endmodule

// File: tb/tb_rib_rr_arbiter.sv
// Randomised + directed bench for rib_rr_arbiter against a cycle-level ownership model.
module tb_rib_rr_arbiter;
  localparam int MAXH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_i, lock_i;
  logic [1:0] grant_o;
  logic       grant_vld_o, hold_flag_o, starve_o;
  logic [3:0] gnt_o;

  int checks = 0;
  int errors = 0;

  // model state
  int m_own, m_last, m_hold;
  bit m_vld, m_starve, m_ok;

  always #5 clk = ~clk;

  rib_rr_arbiter #(.NUM_M(4), .MAX_HOLD(MAXH), .HCW(8)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .lock_i(lock_i),
    .grant_o(grant_o), .grant_vld_o(grant_vld_o), .gnt_o(gnt_o),
    .hold_flag_o(hold_flag_o), .starve_o(starve_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int arb(input int r, input int p);
`ifdef RIB_ARB_PRIO3_EN
    if (r[3]) return 3;
`endif
    for (int k = 1; k <= 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return p;
  endfunction

  task automatic model_step(input int r, input int l, input bit rs);
    int o;
    bit lk;
    if (rs) begin
      m_vld = 0; m_own = 1; m_last = 3; m_hold = 0; m_starve = 0; m_ok = 1;
      return;
    end
    m_starve = 0;
    if (!m_vld) begin
      if (r != 0) begin
        m_own = arb(r, m_last); m_vld = 1; m_hold = 0;
      end
    end else begin
      o  = m_own;
      lk = r[o] && l[o];
`ifdef RIB_ARB_PRIO3_EN
      if (r[3] && o != 3) begin
        m_starve = lk; m_own = 3; m_hold = 0; m_last = 3;
        return;
      end
`endif
      if (lk && m_hold < MAXH - 1) m_hold++;
      else if (lk) begin
        m_hold = 0;
        if ((r & ~(1 << o)) != 0) begin
          m_own = arb(r & ~(1 << o), o); m_starve = 1;
        end
      end else if (r != 0) begin
        m_own = arb(r, o); m_hold = 0;
      end else begin
        m_vld = 0; m_hold = 0;
      end
    end
    if (m_vld) m_last = m_own;
  endtask

  // One cycle: drive at negedge, check comb flag, clock, then check registered outputs.
  task automatic step(input logic [3:0] r, input logic [3:0] l, input logic rs);
    bit hf;
    req_i = r; lock_i = l; rst = rs;
    #1;
    if (m_ok) begin
      hf = r[0] | r[2] | r[3] | (m_vld && m_own != 1);
      chk("hold_flag", 32'(hold_flag_o), 32'(hf));
    end
    @(posedge clk);
    model_step(int'(r), int'(l), rs);
    @(negedge clk);
    chk("grant_vld", 32'(grant_vld_o), 32'(m_vld));
    chk("grant", 32'(grant_o), 32'(m_own));
    chk("gnt", 32'(gnt_o), m_vld ? (32'd1 << m_own) : 32'd0);
    chk("starve", 32'(starve_o), 32'(m_starve));
  endtask

  int starve_cnt;

  initial begin
    m_ok = 0; m_vld = 0; m_own = 1; m_last = 3; m_hold = 0; m_starve = 0;
    req_i = '0; lock_i = '0; rst = 1'b1;
    @(negedge clk);
    step(4'h0, 4'h0, 1'b1);
    chk("reset_grant", 32'(grant_o), 32'h1);
    step(4'h0, 4'h0, 1'b1);
    // all request, unlocked: rotation 0,1,2,3
    for (int i = 0; i < 8; i++) begin
      step(4'hF, 4'h0, 1'b0);
      chk("rot_seq", 32'(grant_o), 32'(i % 4));
    end
    // fetch only
    for (int i = 0; i < 4; i++) step(4'h2, 4'h0, 1'b0);
    step(4'h0, 4'h0, 1'b0);
    chk("idle_keep_grant", 32'(grant_o), 32'h1);
    // m0 locked against m2 from IDLE
    starve_cnt = 0;
    step(4'h0, 4'h0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(4'h5, 4'h1, 1'b0);
      if (starve_o) starve_cnt++;
    end
    chk("starve_once", 32'(starve_cnt), 32'd1);
    // m2 alone locked for 20 cycles
    starve_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(4'h4, 4'h4, 1'b0);
      if (starve_o) starve_cnt++;
    end
    chk("alone_no_starve", 32'(starve_cnt), 32'd0);
    // reset during m0 locked burst, then 0011 -> m0
    step(4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(4'h1, 4'h1, 1'b0);
    step(4'h1, 4'h1, 1'b1);
    step(4'h3, 4'h0, 1'b0);
    chk("post_rst_grant0", 32'(grant_o), 32'h0);
    // m0 locked, m3 arrives at hold_cnt 2
    step(4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(4'h1, 4'h1, 1'b0);
    for (int i = 0; i < 8; i++) step(4'h9, 4'h1, 1'b0);
    // random traffic with sticky-ish lock
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] r, l;
      r = 4'($urandom);
      l = ($urandom_range(0, 3) != 0) ? 4'($urandom) | 4'($urandom) : 4'h0;
      step(r, l, ($urandom_range(0, 199) == 0));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1);
  end
endmodule
